board_writer: RTL and testbench

- Owns the 3x3 tic-tac-toe board state and commits moves at the cursor position chosen by the box selector.
- Alternates turns between X and O, detects a win or a draw, and freezes the board once the game is over.
- Drives the cell-state bus out0..out8 that the box selector reads back. Also drives a red-pixel overlay of the placed marks for the 16x16 LED matrix.

---
 rtl/tictactoe_pkg.sv | 32 +++
 rtl/board_writer_if.sv | 32 +++
 rtl/board_writer_line_checker.sv | 29 ++
 rtl/board_writer.sv | 146 ++++++++++++++
 tb/tb_board_writer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board.
// Cell encodings, game states, winner codes and LED pixel offsets.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    TURN_X,
    TURN_O,
    WIN_X,
    WIN_O,
    DRAW
  } game_state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_X    = 2'b01;
  localparam logic [1:0] WINNER_O    = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam logic [3:0] NO_BOX  = 4'd9;
  localparam logic [3:0] MAX_BOX = 4'd8;

  // Top pixel row of board row 0, leftmost bit of board column 0, block pitch.
  localparam logic [3:0] PIX_ROW0 = 4'd2;
  localparam logic [3:0] PIX_COL0 = 4'd13;
  localparam logic [3:0] PIX_STEP = 4'd5;

endpackage

// File: rtl/board_writer_if.sv
// Board writer bus: cursor/move controls in, board state and overlay out.
// The master side drives moves, the slave side owns the board.
interface board_writer_if;
  logic [3:0]        curBox;
  logic              place;
  logic              newGame;
  logic [1:0]        out0, out1, out2;
  logic [1:0]        out3, out4, out5;
  logic [1:0]        out6, out7, out8;
  logic [1:0]        turn;
  logic [1:0]        winner;
  logic              gameOver;
  logic              accepted;
  logic              rejected;
  logic [15:0][15:0] RedPixels;

  modport master (
    output curBox, place, newGame,
    input  out0, out1, out2, out3, out4,
    input  out5, out6, out7, out8,
    input  turn, winner, gameOver,
    input  accepted, rejected, RedPixels
  );

  modport slave (
    input  curBox, place, newGame,
    output out0, out1, out2, out3, out4,
    output out5, out6, out7, out8,
    output turn, winner, gameOver,
    output accepted, rejected, RedPixels
  );
endinterface

// File: rtl/board_writer_line_checker.sv
// Combinational win detector: flags any row, column or diagonal
// whose three cells all equal the given mark.
module line_checker
  import tictactoe_pkg::*;
(
  input  cell_t cells [9],
  input  cell_t mark,
  output logic  win
);

  logic [8:0] m;

  always_comb begin
    m = '0;
    for (int i = 0; i < 9; i++) begin
      m[i] = (cells[i] == mark);
    end
  end

  assign win = (m[0] & m[1] & m[2])
             | (m[3] & m[4] & m[5])
             | (m[6] & m[7] & m[8])
             | (m[0] & m[3] & m[6])
             | (m[1] & m[4] & m[7])
             | (m[2] & m[5] & m[8])
             | (m[0] & m[4] & m[8])
             | (m[2] & m[4] & m[6]);

endmodule

// File: rtl/board_writer.sv
// Tic-tac-toe board owner: commits moves, alternates turns,
// detects win/draw and renders the red mark overlay.
module board_writer
  import tictactoe_pkg::*;
#(
  parameter logic [1:0] FIRST_MARK = 2'b01,
  parameter logic [3:0] NO_BOX_P   = NO_BOX
) (
  input  logic          clk,
  input  logic          reset,
  board_writer_if.slave bus
);

  localparam game_state_t FIRST_STATE =
    (FIRST_MARK == 2'b10) ? TURN_O : TURN_X;

  cell_t       board   [9];
  cell_t       board_n [9];
  cell_t       wr_board [9];
  game_state_t state, state_n;
  logic        acc_n, rej_n;
  logic        acc_q, rej_q;
  cell_t       mark;
  logic        playing, can_place, win, full;

  always_comb begin
    mark      = (state == TURN_O) ? MARK_O : MARK_X;
    playing   = (state == TURN_X) || (state == TURN_O);
    // NO_BOX and above never address a cell
    can_place = playing && (bus.curBox <= MAX_BOX)
              && (bus.curBox < NO_BOX_P)
              && (board[bus.curBox] == EMPTY);
    wr_board  = board;
    if (can_place) wr_board[bus.curBox] = mark;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (wr_board[i] == EMPTY) full = 1'b0;
    end
  end

  line_checker u_lines (
    .cells (wr_board),
    .mark  (mark),
    .win   (win)
  );

  always_comb begin
    board_n = board;
    state_n = state;
    acc_n   = 1'b0;
    rej_n   = 1'b0;
    if (bus.newGame) begin
      for (int i = 0; i < 9; i++) board_n[i] = EMPTY;
      state_n = FIRST_STATE;
    end else if (bus.place) begin
      if (can_place) begin
        board_n = wr_board;
        acc_n   = 1'b1;
        if (win)
          state_n = (mark == MARK_X) ? WIN_X : WIN_O;
        else if (full)
          state_n = DRAW;
        else
          state_n = (mark == MARK_X) ? TURN_O : TURN_X;
      end else begin
        rej_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) board[i] <= EMPTY;
      state <= FIRST_STATE;
      acc_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      board <= board_n;
      state <= state_n;
      acc_q <= acc_n;
      rej_q <= rej_n;
    end
  end

  always_comb begin
    bus.turn     = 2'b00;
    bus.winner   = WINNER_NONE;
    bus.gameOver = 1'b0;
    unique case (state)
      TURN_X: bus.turn = MARK_X;
      TURN_O: bus.turn = MARK_O;
      WIN_X: begin
        bus.winner   = WINNER_X;
        bus.gameOver = 1'b1;
      end
      WIN_O: begin
        bus.winner   = WINNER_O;
        bus.gameOver = 1'b1;
      end
      DRAW: begin
        bus.winner   = WINNER_DRAW;
        bus.gameOver = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.accepted = acc_q;
  assign bus.rejected = rej_q;
  assign bus.out0 = board[0];
  assign bus.out1 = board[1];
  assign bus.out2 = board[2];
  assign bus.out3 = board[3];
  assign bus.out4 = board[4];
  assign bus.out5 = board[5];
  assign bus.out6 = board[6];
  assign bus.out7 = board[7];
  assign bus.out8 = board[8];

  logic [3:0] k, tr, lc;

  // X fills its 2x2 block; O lights only the main diagonal of it
  always_comb begin
    bus.RedPixels = '0;
    k  = '0;
    tr = '0;
    lc = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        k  = 4'(3 * r + c);
        tr = PIX_ROW0 + 4'(r) * PIX_STEP;
        lc = PIX_COL0 - 4'(c) * PIX_STEP;
        if (board[k] == MARK_X) begin
          bus.RedPixels[tr][lc]               = 1'b1;
          bus.RedPixels[tr][lc - 4'd1]        = 1'b1;
          bus.RedPixels[tr + 4'd1][lc]        = 1'b1;
          bus.RedPixels[tr + 4'd1][lc - 4'd1] = 1'b1;
        end else if (board[k] == MARK_O) begin
          bus.RedPixels[tr][lc]               = 1'b1;
          bus.RedPixels[tr + 4'd1][lc - 4'd1] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Directed testbench for board_writer: moves, win, draw,
// rejects, newGame priority, async reset, overlay.
module tb_board_writer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  board_writer_if bi ();
  board_writer_if bo ();

  board_writer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bi)
  );

  board_writer #(.FIRST_MARK(2'b10)) u_dut_o (
    .clk   (clk),
    .reset (reset),
    .bus   (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] cells [9];
  assign cells[0] = bi.out0;
  assign cells[1] = bi.out1;
  assign cells[2] = bi.out2;
  assign cells[3] = bi.out3;
  assign cells[4] = bi.out4;
  assign cells[5] = bi.out5;
  assign cells[6] = bi.out6;
  assign cells[7] = bi.out7;
  assign cells[8] = bi.out8;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_place(input logic [3:0] box);
    @(negedge clk);
    bi.curBox = box;
    bi.place  = 1'b1;
    @(negedge clk);
    bi.place  = 1'b0;
  endtask

  task automatic do_new();
    @(negedge clk);
    bi.newGame = 1'b1;
    @(negedge clk);
    bi.newGame = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) chk("reset_cell", 32'(cells[i]), 0);
    chk("reset_turn", 32'(bi.turn), 1);
    chk("reset_winner", 32'(bi.winner), 0);
    chk("reset_gameover", 32'(bi.gameOver), 0);
    chk("reset_acc", 32'(bi.accepted), 0);
    chk("reset_rej", 32'(bi.rejected), 0);
    chk("reset_turn_o", 32'(bo.turn), 2);
    reset = 1'b0;
  endtask

  task automatic test_accept_reject();
    do_place(4'd4);
    chk("acc_out4", 32'(bi.out4), 1);
    chk("acc_pulse", 32'(bi.accepted), 1);
    chk("acc_norej", 32'(bi.rejected), 0);
    chk("acc_turn", 32'(bi.turn), 2);
    @(negedge clk);
    chk("acc_once", 32'(bi.accepted), 0);
    do_place(4'd4);
    chk("rej_out4", 32'(bi.out4), 1);
    chk("rej_pulse", 32'(bi.rejected), 1);
    chk("rej_noacc", 32'(bi.accepted), 0);
    chk("rej_turn", 32'(bi.turn), 2);
    @(negedge clk);
    chk("rej_once", 32'(bi.rejected), 0);
  endtask

  task automatic test_win();
    do_new();
    chk("new_turn", 32'(bi.turn), 1);
    chk("new_out4", 32'(bi.out4), 0);
    do_place(4'd0);
    do_place(4'd3);
    do_place(4'd1);
    do_place(4'd4);
    chk("prewin_over", 32'(bi.gameOver), 0);
    do_place(4'd2);
    chk("win_row", {26'd0, bi.out0, bi.out1, bi.out2}, 32'h15);
    chk("win_winner", 32'(bi.winner), 1);
    chk("win_over", 32'(bi.gameOver), 1);
    chk("win_turn", 32'(bi.turn), 0);
    do_place(4'd8);
    chk("win_rej", 32'(bi.rejected), 1);
    chk("win_out8", 32'(bi.out8), 0);
    chk("win_hold", 32'(bi.winner), 1);
    do_new();
    chk("win_clear", 32'(bi.winner), 0);
    chk("win_clr_over", 32'(bi.gameOver), 0);
  endtask

  task automatic test_draw();
    logic [3:0] seq [9];
    seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    do_new();
    for (int i = 0; i < 8; i++) do_place(seq[i]);
    chk("draw_pre", 32'(bi.gameOver), 0);
    do_place(seq[8]);
    chk("draw_acc", 32'(bi.accepted), 1);
    chk("draw_winner", 32'(bi.winner), 3);
    chk("draw_over", 32'(bi.gameOver), 1);
    chk("draw_turn", 32'(bi.turn), 0);
    chk("draw_out6", 32'(bi.out6), 2);
  endtask

  task automatic test_nobox_newgame();
    do_new();
    do_place(4'd0);
    do_place(4'd9);
    chk("nobox_rej", 32'(bi.rejected), 1);
    chk("nobox_out0", 32'(bi.out0), 1);
    chk("nobox_turn", 32'(bi.turn), 2);
    do_place(4'd15);
    chk("box15_rej", 32'(bi.rejected), 1);
    do_place(4'd5);
    @(negedge clk);
    bi.curBox  = 4'd6;
    bi.place   = 1'b1;
    bi.newGame = 1'b1;
    @(negedge clk);
    bi.place   = 1'b0;
    bi.newGame = 1'b0;
    for (int i = 0; i < 9; i++) chk("ng_cell", 32'(cells[i]), 0);
    chk("ng_turn", 32'(bi.turn), 1);
    chk("ng_acc", 32'(bi.accepted), 0);
    chk("ng_rej", 32'(bi.rejected), 0);
  endtask

  task automatic test_async_reset();
    do_place(4'd2);
    do_place(4'd7);
    chk("ar_pre", 32'(bi.out7), 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_out2", 32'(bi.out2), 0);
    chk("ar_out7", 32'(bi.out7), 0);
    chk("ar_turn", 32'(bi.turn), 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_o();
    @(negedge clk);
    bo.curBox = 4'd0;
    bo.place  = 1'b1;
    @(negedge clk);
    bo.place  = 1'b0;
    chk("fo_out0", 32'(bo.out0), 2);
    chk("fo_turn", 32'(bo.turn), 1);
    chk("fo_acc", 32'(bo.accepted), 1);
  endtask

  task automatic test_pixels();
    do_new();
    chk("pix_empty", 32'(|bi.RedPixels), 0);
    do_place(4'd0);
    do_place(4'd8);
    chk("pix_r2", 32'(bi.RedPixels[2]), 32'h3000);
    chk("pix_r3", 32'(bi.RedPixels[3]), 32'h3000);
    chk("pix_r12", 32'(bi.RedPixels[12]), 32'h0008);
    chk("pix_r13", 32'(bi.RedPixels[13]), 32'h0004);
    chk("pix_r7", 32'(bi.RedPixels[7]), 0);
    chk("pix_r4", 32'(bi.RedPixels[4]), 0);
    do_place(4'd4);
    chk("pix_x4_r7", 32'(bi.RedPixels[7]), 32'h0180);
    chk("pix_x4_r8", 32'(bi.RedPixels[8]), 32'h0180);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    bi.curBox  = 4'd0;
    bi.place   = 1'b0;
    bi.newGame = 1'b0;
    bo.curBox  = 4'd0;
    bo.place   = 1'b0;
    bo.newGame = 1'b0;
    test_reset();
    test_accept_reject();
    test_win();
    test_draw();
    test_nobox_newgame();
    test_async_reset();
    test_first_o();
    test_pixels();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
